// File: rtl/osc_pkg.sv
// Shared types and constants for the oscilloscope capture path.
package osc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } cap_state_t;

  localparam int         DEPTH_DEFAULT = 800;
  localparam logic [7:0] Y_INV         = 8'd255;

  // Screen Y grows downward, so larger samples map to smaller row numbers.
  function automatic logic [7:0] y_invert(input logic [7:0] sample);
    return Y_INV - sample;
  endfunction

endpackage

// File: rtl/strobe_sync.sv
// Brings the asynchronous ADC strobe into CLK_50M and emits a one-cycle
// sample_stb with the sample captured alongside it.
module strobe_sync (
  input  logic       CLK_50M,
  input  logic       RST_N,
  input  logic       AD_CS,
  input  logic [7:0] in_ad_data,
  output logic       sample_stb,
  output logic [7:0] sample_data
);

  logic sync1_reg;
  logic sync2_reg;
  logic sync3_reg;

  // Data is taken while sync2 is still low, i.e. on the same edge that raises
  // sample_stb; in_ad_data has been stable since AD_CS went high.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      sync3_reg   <= 1'b0;
      sample_data <= 8'd0;
    end else begin
      sync1_reg <= AD_CS;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
      if (sync1_reg && !sync2_reg)
        sample_data <= in_ad_data;
    end
  end

  assign sample_stb = sync2_reg && !sync3_reg;

endmodule

// File: rtl/capture_trigger_ctrl.sv
// Edge-triggered frame capture controller feeding the capture RAM.
// Optional forced trigger after a timeout in ARMED: define TRIG_TIMEOUT_EN.
module capture_trigger_ctrl
  import osc_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEFAULT,
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic              CLK_50M,
  input  logic              RST_N,
  input  logic              AD_CS,
  input  logic [7:0]        in_ad_data,
  input  logic [7:0]        trig_level,
  input  logic              trig_slope,
  input  logic              arm,
  input  logic              frame_done,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              capture_busy,
  output logic              capture_valid,
  output logic              trig_timeout
);

  cap_state_t        state_reg;
  logic              sample_stb;
  logic [7:0]        sample_data;
  logic [7:0]        prev_reg;
  logic              prev_valid_reg;
  logic              trig_hit;
  logic              tmo_reached;
  logic              enter_armed;
  logic [ADDR_W-1:0] addr_next;

  strobe_sync u_strobe_sync (
    .CLK_50M    (CLK_50M),
    .RST_N      (RST_N),
    .AD_CS      (AD_CS),
    .in_ad_data (in_ad_data),
    .sample_stb (sample_stb),
    .sample_data(sample_data)
  );

  always_comb begin
    trig_hit = 1'b0;
    if (prev_valid_reg) begin
      if (trig_slope)
        trig_hit = (prev_reg < trig_level) && (sample_data >= trig_level);
      else
        trig_hit = (prev_reg >= trig_level) && (sample_data < trig_level);
    end
  end

  assign enter_armed = ((state_reg == ST_IDLE) && arm) ||
                       ((state_reg == ST_DONE) && frame_done);
  assign addr_next   = wr_addr + 1'b1;

`ifdef TRIG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_cnt_reg;
  logic          tmo_flag_reg;

  assign tmo_reached = (tmo_cnt_reg == TW'(TIMEOUT_CYC - 1));

  // Counter saturates at TIMEOUT_CYC-1 so the first strobe afterwards fires.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      tmo_cnt_reg  <= '0;
      tmo_flag_reg <= 1'b0;
    end else if (enter_armed) begin
      tmo_cnt_reg  <= '0;
      tmo_flag_reg <= 1'b0;
    end else if (state_reg == ST_ARMED) begin
      if (tmo_reached) begin
        if (sample_stb)
          tmo_flag_reg <= 1'b1;
      end else begin
        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      end
    end
  end

  assign trig_timeout = tmo_flag_reg;
`else
  assign tmo_reached  = 1'b0;
  assign trig_timeout = 1'b0;
`endif

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state_reg      <= ST_IDLE;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= 8'd0;
      capture_busy   <= 1'b0;
      capture_valid  <= 1'b0;
      prev_reg       <= 8'd0;
      prev_valid_reg <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (arm) begin
            state_reg      <= ST_ARMED;
            capture_busy   <= 1'b1;
            prev_valid_reg <= 1'b0;
          end
        end
        ST_ARMED: begin
          if (sample_stb) begin
            prev_reg       <= sample_data;
            prev_valid_reg <= 1'b1;
            if (trig_hit || tmo_reached) begin
              wr_en   <= 1'b1;
              wr_addr <= '0;
              wr_data <= y_invert(sample_data);
              if (DEPTH == 1) begin
                state_reg     <= ST_DONE;
                capture_busy  <= 1'b0;
                capture_valid <= 1'b1;
              end else begin
                state_reg <= ST_CAPTURE;
              end
            end
          end
        end
        ST_CAPTURE: begin
          if (sample_stb) begin
            wr_en   <= 1'b1;
            wr_addr <= addr_next;
            wr_data <= y_invert(sample_data);
            if (addr_next == ADDR_W'(DEPTH - 1)) begin
              state_reg     <= ST_DONE;
              capture_busy  <= 1'b0;
              capture_valid <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          // frame_done alone decides; a coincident arm is irrelevant here.
          if (frame_done) begin
            state_reg      <= ST_ARMED;
            capture_busy   <= 1'b1;
            capture_valid  <= 1'b0;
            prev_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_trigger_ctrl.sv
// Directed bench for capture_trigger_ctrl; define TRIG_TIMEOUT_EN to also
// exercise the forced trigger with a short timeout.
module tb_capture_trigger_ctrl;

`ifdef TRIG_TIMEOUT_EN
  localparam int TMO = 1000;
`else
  localparam int TMO = 50_000_000;
`endif

  logic        CLK_50M;
  logic        RST_N;
  logic        AD_CS;
  logic [7:0]  in_ad_data;
  logic [7:0]  trig_level;
  logic        trig_slope;
  logic        arm;
  logic        frame_done;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        capture_busy;
  logic        capture_valid;
  logic        trig_timeout;

  int vec_cnt = 0;
  int err_cnt = 0;
  int wr_cnt  = 0;

  capture_trigger_ctrl #(
    .DEPTH      (800),
    .ADDR_W     (16),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .CLK_50M      (CLK_50M),
    .RST_N        (RST_N),
    .AD_CS        (AD_CS),
    .in_ad_data   (in_ad_data),
    .trig_level   (trig_level),
    .trig_slope   (trig_slope),
    .arm          (arm),
    .frame_done   (frame_done),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .capture_busy (capture_busy),
    .capture_valid(capture_valid),
    .trig_timeout (trig_timeout)
  );

  initial CLK_50M = 1'b0;
  always #10 CLK_50M = ~CLK_50M;

  always @(negedge CLK_50M) if (wr_en === 1'b1) wr_cnt++;

  // One ADC conversion: AD_CS high for 4 clocks, low for 4. Captures wr_en
  // after the 2nd and 3rd rising edges following the first high sample.
  task automatic strobe(input logic [7:0] v, output logic we2, output logic we3,
                        output logic [15:0] a3, output logic [7:0] d3);
    @(negedge CLK_50M);
    in_ad_data = v;
    AD_CS      = 1'b1;
    @(negedge CLK_50M);
    @(negedge CLK_50M);
    we2 = wr_en;
    @(negedge CLK_50M);
    we3 = wr_en;
    a3  = wr_addr;
    d3  = wr_data;
    @(negedge CLK_50M);
    AD_CS = 1'b0;
    repeat (3) @(negedge CLK_50M);
  endtask

  task automatic pulse_arm();
    @(negedge CLK_50M); arm = 1'b1;
    @(negedge CLK_50M); arm = 1'b0;
  endtask

  task automatic pulse_frame_done();
    @(negedge CLK_50M); frame_done = 1'b1;
    @(negedge CLK_50M); frame_done = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK_50M);
    vec_cnt++;
    if ({wr_en, wr_addr, wr_data, capture_busy, capture_valid, trig_timeout} !== 28'd0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got en=%b addr=%0d data=%0d busy=%b valid=%b tmo=%b, want all 0",
               wr_en, wr_addr, wr_data, capture_busy, capture_valid, trig_timeout);
    end
    RST_N = 1'b1;
    pulse_frame_done();
    vec_cnt++;
    if (capture_busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL frame_done_in_idle: busy=%b want 0", capture_busy);
    end
  endtask

  task automatic test_rising();
    logic we2, we3; logic [15:0] a3; logic [7:0] d3;
    trig_slope = 1'b1; trig_level = 8'd128;
    pulse_arm();
    vec_cnt++;
    if (capture_busy !== 1'b1) begin
      err_cnt++; $display("FAIL arm_busy: busy=%b want 1", capture_busy);
    end
    strobe(8'd100, we2, we3, a3, d3);
    vec_cnt++;
    if (we3 !== 1'b0) begin err_cnt++; $display("FAIL rise_s100: wr_en=%b want 0", we3); end
    strobe(8'd120, we2, we3, a3, d3);
    vec_cnt++;
    if (we3 !== 1'b0) begin err_cnt++; $display("FAIL rise_s120: wr_en=%b want 0", we3); end
    strobe(8'd130, we2, we3, a3, d3);
    vec_cnt++;
    if ({we2, we3, a3, d3, trig_timeout} !== {1'b0, 1'b1, 16'd0, 8'd125, 1'b0}) begin
      err_cnt++;
      $display("FAIL rise_trigger: we@2=%b we@3=%b addr=%0d data=%0d tmo=%b, want 0 1 0 125 0",
               we2, we3, a3, d3, trig_timeout);
    end
  endtask

  task automatic test_full_frame();
    logic we2, we3; logic [15:0] a3; logic [7:0] d3;
    int w0;
    for (int i = 1; i < 800; i++) begin
      logic [7:0] v;
      v = 8'(i * 7);
      strobe(v, we2, we3, a3, d3);
      vec_cnt++;
      if ({we3, a3, d3} !== {1'b1, 16'(i), 8'(255 - int'(v))}) begin
        err_cnt++;
        $display("FAIL frame_write_%0d: en=%b addr=%0d data=%0d, want 1 %0d %0d",
                 i, we3, a3, d3, i, 255 - int'(v));
      end
    end
    vec_cnt++;
    if ({capture_valid, capture_busy} !== 2'b10) begin
      err_cnt++;
      $display("FAIL frame_done_flags: valid=%b busy=%b want 1 0", capture_valid, capture_busy);
    end
    w0 = wr_cnt;
    strobe(8'd10, we2, we3, a3, d3);
    strobe(8'd200, we2, we3, a3, d3);
    pulse_arm();
    vec_cnt++;
    if (wr_cnt !== w0 || capture_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL done_idle_writes: extra writes=%0d valid=%b want 0 1", wr_cnt - w0, capture_valid);
    end
  endtask

  task automatic test_coincide();
    @(negedge CLK_50M); arm = 1'b1; frame_done = 1'b1;
    @(negedge CLK_50M); arm = 1'b0; frame_done = 1'b0;
    vec_cnt++;
    if ({capture_busy, capture_valid} !== 2'b10) begin
      err_cnt++;
      $display("FAIL coincide: busy=%b valid=%b want 1 0", capture_busy, capture_valid);
    end
  endtask

  task automatic test_falling();
    logic we2, we3; logic [15:0] a3; logic [7:0] d3;
    trig_slope = 1'b0; trig_level = 8'd100;
    strobe(8'd90, we2, we3, a3, d3);
    vec_cnt++;
    if (we3 !== 1'b0) begin err_cnt++; $display("FAIL fall_first90: wr_en=%b want 0", we3); end
    strobe(8'd200, we2, we3, a3, d3);
    vec_cnt++;
    if (we3 !== 1'b0) begin err_cnt++; $display("FAIL fall_s200: wr_en=%b want 0", we3); end
    strobe(8'd90, we2, we3, a3, d3);
    vec_cnt++;
    if ({we3, a3, d3} !== {1'b1, 16'd0, 8'd165}) begin
      err_cnt++;
      $display("FAIL fall_trigger: en=%b addr=%0d data=%0d want 1 0 165", we3, a3, d3);
    end
  endtask

  task automatic test_mid_reset();
    logic we2, we3; logic [15:0] a3; logic [7:0] d3;
    for (int i = 1; i <= 400; i++) begin
      strobe(8'd60, we2, we3, a3, d3);
      vec_cnt++;
      if ({we3, a3} !== {1'b1, 16'(i)}) begin
        err_cnt++;
        $display("FAIL partial_write_%0d: en=%b addr=%0d want 1 %0d", i, we3, a3, i);
      end
    end
    @(negedge CLK_50M); RST_N = 1'b0;
    #2;
    vec_cnt++;
    if ({wr_en, wr_addr, wr_data, capture_busy, capture_valid, trig_timeout} !== 28'd0) begin
      err_cnt++;
      $display("FAIL async_reset: en=%b addr=%0d data=%0d busy=%b valid=%b tmo=%b, want all 0",
               wr_en, wr_addr, wr_data, capture_busy, capture_valid, trig_timeout);
    end
    @(negedge CLK_50M); RST_N = 1'b1;
    pulse_arm();
    pulse_frame_done();
    vec_cnt++;
    if ({capture_busy, capture_valid} !== 2'b10) begin
      err_cnt++;
      $display("FAIL frame_done_in_armed: busy=%b valid=%b want 1 0", capture_busy, capture_valid);
    end
    trig_slope = 1'b1; trig_level = 8'd128;
    strobe(8'd100, we2, we3, a3, d3);
    strobe(8'd130, we2, we3, a3, d3);
    vec_cnt++;
    if ({we3, a3, d3} !== {1'b1, 16'd0, 8'd125}) begin
      err_cnt++;
      $display("FAIL rearm_trigger: en=%b addr=%0d data=%0d want 1 0 125", we3, a3, d3);
    end
  endtask

  task automatic test_timeout();
    logic we2, we3; logic [15:0] a3; logic [7:0] d3;
    @(negedge CLK_50M); RST_N = 1'b0;
    @(negedge CLK_50M); RST_N = 1'b1;
    trig_slope = 1'b1; trig_level = 8'd128;
    pulse_arm();
    strobe(8'd50, we2, we3, a3, d3);
    vec_cnt++;
    if (we3 !== 1'b0) begin err_cnt++; $display("FAIL tmo_early: wr_en=%b want 0", we3); end
    repeat (1010) @(negedge CLK_50M);
    strobe(8'd50, we2, we3, a3, d3);
`ifdef TRIG_TIMEOUT_EN
    vec_cnt++;
    if ({we3, a3, d3, trig_timeout} !== {1'b1, 16'd0, 8'd205, 1'b1}) begin
      err_cnt++;
      $display("FAIL tmo_forced: en=%b addr=%0d data=%0d tmo=%b want 1 0 205 1", we3, a3, d3, trig_timeout);
    end
`else
    vec_cnt++;
    if ({we3, trig_timeout, capture_busy} !== 3'b001) begin
      err_cnt++;
      $display("FAIL tmo_disabled: en=%b tmo=%b busy=%b want 0 0 1", we3, trig_timeout, capture_busy);
    end
`endif
  endtask

  initial begin
    RST_N = 1'b0; AD_CS = 1'b0; in_ad_data = 8'd0;
    trig_level = 8'd0; trig_slope = 1'b1; arm = 1'b0; frame_done = 1'b0;
    test_reset();
    test_rising();
    test_full_frame();
    test_coincide();
    test_falling();
    test_mid_reset();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
